// File: rtl/seq_chk_pkg.sv
// Shared types and elaboration helpers for the sequence window checker.
package seq_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_e;

    // ceil(log2(value)), but never less than 1 so a counter always has a bit
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/seq_chk_channel.sv
// One antecedent/consequent window checker: a single FSM plus its delay count.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no check in flight; a sampled every edge (also on pulse cycles)
//   WAIT  | a seen, counting clocks until b arrives or the window closes
module seq_chk_channel
    import seq_chk_pkg::*;
#(
    parameter int MIN_DLY = 0,
    parameter int MAX_DLY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic pass_pulse,
    output logic fail_pulse,
    output logic busy
);

    localparam int DLY_W = clog2_min1(MAX_DLY + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(MAX_DLY);

    seq_state_e       state;
    logic [DLY_W-1:0] dly;
    logic             min_ok;

    // b only counts once the elapsed delay has reached the window start;
    // compared as int so a zero MIN_DLY does not turn into an unsigned >= 0
    assign min_ok = (int'(dly) >= MIN_DLY);

    // state is itself a register, so busy is registered with no extra flop
    assign busy = (state == WAIT);

    // window FSM; pulses default low so each lasts exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dly        <= '0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            if (!en) begin
                state <= IDLE;
                dly   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (a) begin
                            if (b && (MIN_DLY == 0)) begin
                                pass_pulse <= 1'b1;
                            end else if (MAX_DLY == 0) begin
                                fail_pulse <= 1'b1;
                            end else begin
                                state <= WAIT;
                                dly   <= DLY_W'(1);
                            end
                        end
                    end
                    WAIT: begin
                        // a is deliberately ignored here: checks never overlap
                        if (b && min_ok) begin
                            pass_pulse <= 1'b1;
                            state      <= IDLE;
                            dly        <= '0;
                        end else if (dly == DLY_LAST) begin
                            fail_pulse <= 1'b1;
                            state      <= IDLE;
                            dly        <= '0;
                        end else begin
                            dly <= dly + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        dly   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_window_checker.sv
// Multi-channel "a followed by b within [MIN_DLY:MAX_DLY] clocks" checker
// with per-channel pass/fail pulses and saturating aggregate counters.
module seq_window_checker
    import seq_chk_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 0,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_cnt,
    input  logic [NUM_CH-1:0] a,
    input  logic [NUM_CH-1:0] b,
    output logic [NUM_CH-1:0] pass_pulse,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [NUM_CH-1:0] busy,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int PC_W  = clog2_min1(NUM_CH + 1);
    // one spare bit above the wider operand so overflow is visible before clamping
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    if (MIN_DLY > MAX_DLY) begin : g_bad_window
        $error("seq_window_checker: MIN_DLY (%0d) exceeds MAX_DLY (%0d)", MIN_DLY, MAX_DLY);
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("seq_window_checker: NUM_CH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_window_checker: CNT_W must be at least 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        seq_chk_channel #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .a          (a[i]),
            .b          (b[i]),
            .pass_pulse (pass_pulse[i]),
            .fail_pulse (fail_pulse[i]),
            .busy       (busy[i])
        );
    end

    logic [PC_W-1:0]  pass_pop;
    logic [PC_W-1:0]  fail_pop;
    logic [SUM_W-1:0] pass_sum;
    logic [SUM_W-1:0] fail_sum;

    // count this cycle's pulses across channels and form the unclamped totals
    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_pop = pass_pop + PC_W'(pass_pulse[i]);
            fail_pop = fail_pop + PC_W'(fail_pulse[i]);
        end
        pass_sum = SUM_W'(pass_cnt) + SUM_W'(pass_pop);
        fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_pop);
    end

    // saturating totals; a clear beats any increment landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
            fail_cnt <= (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_seq_window_checker.sv
// Bench for seq_window_checker: two configurations driven from the same inputs
// and compared every cycle against a timestamp-based window model.
module tb_seq_window_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_cnt;
    logic [3:0]  a;
    logic [3:0]  b;

    logic [3:0]  pass0, fail0, busy0;
    logic [15:0] pcnt0, fcnt0;
    logic [3:0]  pass1, fail1, busy1;
    logic [2:0]  pcnt1, fcnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_window_checker u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr_cnt    (clr_cnt),
        .a          (a),
        .b          (b),
        .pass_pulse (pass0),
        .fail_pulse (fail0),
        .busy       (busy0),
        .pass_cnt   (pcnt0),
        .fail_cnt   (fcnt0)
    );

    seq_window_checker #(
        .NUM_CH  (4),
        .MIN_DLY (2),
        .MAX_DLY (4),
        .CNT_W   (3)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr_cnt    (clr_cnt),
        .a          (a),
        .b          (b),
        .pass_pulse (pass1),
        .fail_pulse (fail1),
        .busy       (busy1),
        .pass_cnt   (pcnt1),
        .fail_cnt   (fcnt1)
    );

    // reference model: each channel remembers the cycle its antecedent was taken
    int       min_dly [2] = '{0, 2};
    int       max_dly [2] = '{3, 4};
    int       cnt_max [2] = '{65535, 7};
    bit       armed   [2][4];
    int       t0      [2][4];
    bit [3:0] ep      [2];
    bit [3:0] ef      [2];
    int       epc     [2];
    int       efc     [2];
    int       cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                armed[k][i] = 1'b0;
                t0[k][i]    = 0;
            end
            ep[k]  = '0;
            ef[k]  = '0;
            epc[k] = 0;
            efc[k] = 0;
        end
        cyc = 0;
    endtask

    function automatic logic [3:0] model_busy(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = armed[k][i];
        return v;
    endfunction

    // advance the model by one clock edge using the inputs applied before it
    task automatic model_update();
        int       np, nf, el;
        bit [3:0] newp, newf;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            np = $countones(ep[k]);
            nf = $countones(ef[k]);
            if (clr_cnt) begin
                epc[k] = 0;
                efc[k] = 0;
            end else begin
                epc[k] = (epc[k] + np > cnt_max[k]) ? cnt_max[k] : epc[k] + np;
                efc[k] = (efc[k] + nf > cnt_max[k]) ? cnt_max[k] : efc[k] + nf;
            end
            newp = '0;
            newf = '0;
            for (int i = 0; i < 4; i++) begin
                if (!en) begin
                    armed[k][i] = 1'b0;
                end else if (armed[k][i]) begin
                    el = cyc - t0[k][i];
                    if (b[i] && el >= min_dly[k]) begin
                        newp[i] = 1'b1;
                        armed[k][i] = 1'b0;
                    end else if (el >= max_dly[k]) begin
                        newf[i] = 1'b1;
                        armed[k][i] = 1'b0;
                    end
                end else if (a[i]) begin
                    if (b[i] && min_dly[k] == 0) newp[i] = 1'b1;
                    else if (max_dly[k] == 0)    newf[i] = 1'b1;
                    else begin
                        armed[k][i] = 1'b1;
                        t0[k][i]    = cyc;
                    end
                end
            end
            ep[k] = newp;
            ef[k] = newf;
        end
    endtask

    task automatic compare_all();
        check("pass_pulse0", 32'(pass0), 32'(ep[0]));
        check("fail_pulse0", 32'(fail0), 32'(ef[0]));
        check("busy0",       32'(busy0), 32'(model_busy(0)));
        check("pass_cnt0",   32'(pcnt0), 32'(epc[0]));
        check("fail_cnt0",   32'(fcnt0), 32'(efc[0]));
        check("pass_pulse1", 32'(pass1), 32'(ep[1]));
        check("fail_pulse1", 32'(fail1), 32'(ef[1]));
        check("busy1",       32'(busy1), 32'(model_busy(1)));
        check("pass_cnt1",   32'(pcnt1), 32'(epc[1]));
        check("fail_cnt1",   32'(fcnt1), 32'(efc[1]));
    endtask

    // inputs are set at a negedge before calling; outputs checked at the next negedge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [3:0] av, input logic [3:0] bv, input int n);
        a = av;
        b = bv;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr_cnt = 1'b0; a = '0; b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // ch0 same-cycle match, then ch1 antecedent that times out
        drive(4'b0001, 4'b0001, 1);
        drive(4'b0000, 4'b0000, 3);
        drive(4'b0010, 4'b0000, 1);
        drive(4'b0000, 4'b0000, 7);

        // early b ignored then accepted inside the window (MIN_DLY=2 instance)
        drive(4'b1000, 4'b0000, 1);
        drive(4'b0000, 4'b1000, 2);
        drive(4'b0000, 4'b0000, 3);

        // a repeated while waiting must not restart the window
        drive(4'b0100, 4'b0000, 1);
        drive(4'b0100, 4'b0000, 3);
        drive(4'b0000, 4'b0000, 4);

        // all channels back to back every cycle; the 3-bit counter must pin at 7
        drive(4'b1111, 4'b1111, 12);
        drive(4'b0000, 4'b0000, 2);
        check("sat_pass_cnt1", 32'(pcnt1), 32'd7);

        // clear coincident with a pass pulse
        drive(4'b0001, 4'b0001, 1);
        clr_cnt = 1'b1;
        drive(4'b0000, 4'b0000, 1);
        clr_cnt = 1'b0;
        check("clr_wins_pass_cnt0", 32'(pcnt0), 32'd0);
        drive(4'b0000, 4'b0000, 1);

        // disable while ch2 waits: no fail, busy drops
        drive(4'b0100, 4'b0000, 1);
        drive(4'b0000, 4'b0000, 1);
        en = 1'b0;
        drive(4'b0000, 4'b0000, 1);
        en = 1'b1;
        drive(4'b0000, 4'b0000, 5);

        // asynchronous reset in the middle of a wait
        drive(4'b0001, 4'b0000, 1);
        drive(4'b0000, 4'b0000, 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy0", 32'(busy0), 32'd0);
        check("async_rst_busy1", 32'(busy1), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = ($urandom_range(99) < 30);
                b[i] = ($urandom_range(99) < 30);
            end
            en      = ($urandom_range(99) < 95);
            clr_cnt = ($urandom_range(99) < 3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
